// File: rtl/watch_uart_reporter.sv
// Watch event reporter: turns button presses and time reports into ASCII
// frames and feeds them one byte at a time to a uart_tx byte interface.
module watch_uart_reporter #(
    parameter bit SEND_CRLF = 1'b1,
    parameter int BYTE_GAP  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic [3:0] i_btn_pulse,
    input  logic       i_report,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic       i_tx_done,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        GAP,
        DONE
    } state_t;

    localparam logic [3:0] ECHO_LAST = SEND_CRLF ? 4'd2 : 4'd0;
    localparam logic [3:0] REP_LAST  = SEND_CRLF ? 4'd9 : 4'd7;
    localparam logic [7:0] GAP_END   = 8'(BYTE_GAP - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] frame [10];
    logic [3:0] idx;
    logic [3:0] idx_nx;
    logic [3:0] last;
    logic [3:0] last_nx;
    logic [7:0] gap_cnt;
    logic [7:0] gap_cnt_nx;
    logic       pending;
    logic       pending_nx;
    logic       load_echo;
    logic       load_rep;
    logic [7:0] letter;

    function automatic logic [7:0] tens(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return 8'h30 + {2'b00, q};
    endfunction

    function automatic logic [7:0] ones(input logic [5:0] v);
        logic [5:0] r;
        r = v % 6'd10;
        return 8'h30 + {2'b00, r};
    endfunction

    // Several buttons in one cycle: only the highest-priority letter is sent.
    always_comb begin
        letter = 8'h00;
        if (i_btn_pulse[3])
            letter = 8'h55;
        else if (i_btn_pulse[2])
            letter = 8'h44;
        else if (i_btn_pulse[1])
            letter = 8'h4C;
        else if (i_btn_pulse[0])
            letter = 8'h52;
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        last_nx    = last;
        gap_cnt_nx = gap_cnt;
        pending_nx = pending;
        load_echo  = 1'b0;
        load_rep   = 1'b0;

        if (state != IDLE && sel && i_report)
            pending_nx = 1'b1;

        unique case (state)
            IDLE: begin
                if (sel && |i_btn_pulse) begin
                    load_echo = 1'b1;
                    if (i_report)
                        pending_nx = 1'b1;
                end else if (pending || (sel && i_report)) begin
                    load_rep   = 1'b1;
                    pending_nx = 1'b0;
                end
            end
            LOAD: state_nx = SEND;
            SEND: state_nx = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    if (idx == last) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx     = idx + 4'd1;
                        gap_cnt_nx = 8'd0;
                        state_nx   = (BYTE_GAP == 0) ? SEND : GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_END)
                    state_nx = SEND;
                else
                    gap_cnt_nx = gap_cnt + 8'd1;
            end
            DONE: begin
                // A queued report restarts with a fresh time snapshot.
                if (pending) begin
                    load_rep   = 1'b1;
                    pending_nx = sel && i_report;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (load_echo || load_rep) begin
            state_nx = LOAD;
            idx_nx   = 4'd0;
            last_nx  = load_echo ? ECHO_LAST : REP_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 4'd0;
            last    <= 4'd0;
            gap_cnt <= 8'd0;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            last    <= last_nx;
            gap_cnt <= gap_cnt_nx;
            pending <= pending_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 10; i++)
                frame[i] <= 8'h00;
        end else if (load_echo) begin
            frame[0] <= letter;
            frame[1] <= 8'h0D;
            frame[2] <= 8'h0A;
        end else if (load_rep) begin
            frame[0] <= tens({1'b0, i_hour});
            frame[1] <= ones({1'b0, i_hour});
            frame[2] <= 8'h3A;
            frame[3] <= tens(i_min);
            frame[4] <= ones(i_min);
            frame[5] <= 8'h3A;
            frame[6] <= tens(i_sec);
            frame[7] <= ones(i_sec);
            frame[8] <= 8'h0D;
            frame[9] <= 8'h0A;
        end
    end

    assign o_tx_start = (state == SEND);
    assign o_tx_data  = frame[idx];
    assign o_busy     = (state != IDLE) || pending;

endmodule
